// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, transmit FSM state encodings and
// the parity helper used by the transmit serializer.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 11;   // start + 8 data + parity + stop

    // Transmit FSM state encodings
    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_DATA   = 3'd1;
    localparam logic [2:0] TX_PARITY = 3'd2;
    localparam logic [2:0] TX_STOP   = 3'd3;
    localparam logic [2:0] TX_GAP    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = TX_IDLE,
        ST_DATA   = TX_DATA,
        ST_PARITY = TX_PARITY,
        ST_STOP   = TX_STOP,
        ST_GAP    = TX_GAP
    } tx_state_e;

    // Even parity: XOR of all data bits
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host/line signal bundle of the UART transmit FIFO.
// master: host side (drives writes, observes flags and the line).
// slave : the transmit block itself.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int FIFO_WIDTH_T = UART_DATA_BITS
);
    logic                    wr_en;
    logic [FIFO_WIDTH_T-1:0] data_in;
    logic                    TxFF;
    logic                    TxFE;
    logic                    wr_err;
    logic                    busy;
    logic                    data_out;

    modport master (
        output wr_en, data_in,
        input  TxFF, TxFE, wr_err, busy, data_out
    );

    modport slave (
        input  wr_en, data_in,
        output TxFF, TxFE, wr_err, busy, data_out
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Transmit frame FSM: start, DATA_BITS data bits LSB first, parity, stop,
// then STOP_GAP idle periods. Takes entries from the FIFO through a
// pop request/ack pair; an ack is one cycle and coincides with the pop.
// Optional feature macro: TX_PARITY_EN (even parity in the parity slot;
// constant 0 when undefined, frame length unchanged).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int STOP_GAP  = 1
) (
    input  logic                 baud_clk,
    input  logic                 rst_n,
    output logic                 o_pop_req,
    input  logic                 i_pop_ack,
    input  logic [DATA_BITS-1:0] i_pop_data,
    output logic                 o_busy,
    output logic                 o_data_out
);

    localparam int CW = $clog2(DATA_BITS);
    localparam int GW = $clog2(STOP_GAP + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
    localparam logic [GW-1:0] GAP_END  = GW'(STOP_GAP);

    tx_state_e            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [CW-1:0]        r_bit_cnt;
    logic [GW-1:0]        r_gap_cnt;
    logic                 r_busy;
    logic                 r_data_out;

    // Ready for a new entry when idle or when the inter-frame gap has elapsed
    assign o_pop_req = (r_state == ST_IDLE) ||
                       ((r_state == ST_GAP) && (r_gap_cnt == GAP_END));

    assign o_busy     = r_busy;
    assign o_data_out = r_data_out;

    // Frame FSM with registered line and busy outputs
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_busy     <= 1'b0;
            r_data_out <= 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_data_out <= 1'b1;
                    if (i_pop_ack) begin
                        r_shift    <= i_pop_data;
                        r_data_out <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    r_data_out <= r_shift[r_bit_cnt];
                    r_bit_cnt  <= r_bit_cnt + CW'(1);
                    if (r_bit_cnt == LAST_BIT) r_state <= ST_PARITY;
                end
                ST_PARITY: begin
`ifdef TX_PARITY_EN
                    r_data_out <= even_parity(r_shift);
`else
                    r_data_out <= 1'b0;
`endif
                    r_state <= ST_STOP;
                end
                ST_STOP: begin
                    r_data_out <= 1'b1;
                    r_gap_cnt  <= '0;
                    r_state    <= ST_GAP;
                end
                ST_GAP: begin
                    if (r_gap_cnt != GAP_END) begin
                        r_data_out <= 1'b1;
                        r_gap_cnt  <= r_gap_cnt + GW'(1);
                    end else if (i_pop_ack) begin
                        // back-to-back frame: start bit directly after the gap
                        r_shift    <= i_pop_data;
                        r_data_out <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_state    <= ST_DATA;
                    end else begin
                        r_data_out <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_data_out <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: buffers host bytes and hands them to the frame
// serializer. Flags are registered and computed from next-state pointers.
// Optional feature macro: TX_PARITY_EN (passed through to the serializer).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_WIDTH_T = UART_DATA_BITS,
    parameter int FIFO_DEPTH_T = 16,
    parameter int STOP_GAP     = 1
) (
    input  logic          baud_clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus
);

    localparam int AW = $clog2(FIFO_DEPTH_T);

    logic [FIFO_WIDTH_T-1:0] r_mem [FIFO_DEPTH_T];
    logic [AW:0]             r_wr_ptr;
    logic [AW:0]             r_rd_ptr;
    logic                    r_txff;
    logic                    r_txfe;
    logic                    r_wr_err;

    logic                    w_wr_accept;
    logic                    w_pop_req;
    logic                    w_pop_ack;
    logic [AW:0]             w_wr_ptr_nxt;
    logic [AW:0]             w_rd_ptr_nxt;
    logic [FIFO_WIDTH_T-1:0] w_rd_data;

    // A write on a full FIFO is dropped even if a pop happens on the same edge
    assign w_wr_accept  = bus.wr_en & ~r_txff;
    assign w_pop_ack    = w_pop_req & ~r_txfe;
    assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_wr_accept};
    assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop_ack};
    assign w_rd_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Storage write port
    // NOTE: the data array has no reset; only pointers and flags define validity.
    always_ff @(posedge baud_clk) begin
        if (w_wr_accept) r_mem[r_wr_ptr[AW-1:0]] <= bus.data_in;
    end

    // Pointers and registered status flags
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_txff   <= 1'b0;
            r_txfe   <= 1'b1;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_txfe   <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_txff   <= (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                        (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
            r_wr_err <= r_wr_err | (bus.wr_en & r_txff);
        end
    end

    assign bus.TxFF   = r_txff;
    assign bus.TxFE   = r_txfe;
    assign bus.wr_err = r_wr_err;

    uart_tx_serializer #(
        .DATA_BITS (FIFO_WIDTH_T),
        .STOP_GAP  (STOP_GAP)
    ) u_serializer (
        .baud_clk   (baud_clk),
        .rst_n      (rst_n),
        .o_pop_req  (w_pop_req),
        .i_pop_ack  (w_pop_ack),
        .i_pop_data (w_rd_data),
        .o_busy     (bus.busy),
        .o_data_out (bus.data_out)
    );

endmodule
